// File: rtl/count_display_ctrl_pkg.sv
// Shared constants and FSM encoding for the counter -> bin2bcd -> 7-segment path.
package count_display_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT
  } state_t;

  localparam int unsigned NUM_DIGITS  = 4;
  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned BCD_W       = NUM_DIGITS * DIGIT_W;
  localparam int unsigned BIN_W       = 12;
  localparam int unsigned DIGIT_SEL_W = $clog2(NUM_DIGITS);

endpackage

// File: rtl/count_display_ctrl_if.sv
// Start/rdy handshake between the display controller and the external bin2bcd converter.
interface count_display_ctrl_if;
  import count_display_ctrl_pkg::*;

  logic             conv_start;
  logic [BIN_W-1:0] conv_bin;
  logic             conv_rdy;
  logic [BCD_W-1:0] conv_bcd;

  modport master (output conv_start, conv_bin, input conv_rdy, conv_bcd);
  modport slave  (input conv_start, conv_bin, output conv_rdy, conv_bcd);

endinterface

// File: rtl/count_display_ctrl_scan_mux.sv
// Deterministic four-digit scan: divider, digit select, active-low anodes and digit nibble.
module count_display_ctrl_scan_mux
  import count_display_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic [BCD_W-1:0]       bcd,
  output logic [DIGIT_SEL_W-1:0] digit_sel,
  output logic [DIGIT_W-1:0]     digit_bcd,
  output logic [NUM_DIGITS-1:0]  an
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);

  logic [SCAN_W-1:0]      scan_cnt;
  logic                   step;
  logic [DIGIT_SEL_W-1:0] sel_next;

  assign step     = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign sel_next = step ? digit_sel + 1'b1 : digit_sel;

  // an/digit_bcd are built from the next select so they switch on the same edge as digit_sel
  always_ff @(posedge mclk) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_sel <= '0;
      an        <= ~NUM_DIGITS'(1);
      digit_bcd <= '0;
    end else begin
      scan_cnt  <= step ? '0 : scan_cnt + 1'b1;
      digit_sel <= sel_next;
      an        <= ~(NUM_DIGITS'(1) << sel_next);
      digit_bcd <= bcd[DIGIT_W*sel_next +: DIGIT_W];
    end
  end

endmodule

// File: rtl/count_display_ctrl.sv
// Paces a 12-bit counter, drives the bin2bcd handshake with timeout, and feeds the display scan.
module count_display_ctrl
  import count_display_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned SCAN_DIV = 100_000,
  parameter int unsigned CNT_MAX  = 4095,
  parameter int unsigned TIMEOUT  = 31
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic                   run,
  count_display_ctrl_if.master   conv,
  output logic [BCD_W-1:0]       stat_bcd,
  output logic [DIGIT_SEL_W-1:0] digit_sel,
  output logic [DIGIT_W-1:0]     digit_bcd,
  output logic [NUM_DIGITS-1:0]  an,
  output logic                   err
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

  state_t            state, state_next;
  logic [TICK_W-1:0] tick_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [BIN_W-1:0]  count;
  logic [BIN_W-1:0]  count_next;
  logic              tick;
  logic              pending;
  logic              launch;
  logic              to_hit;

  assign tick       = run && (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign launch     = (state == ST_IDLE) && (tick || pending);
  assign to_hit     = (to_cnt == TO_W'(TIMEOUT - 1));
  assign count_next = (count == BIN_W'(CNT_MAX)) ? '0 : count + 1'b1;

  // count only changes on IDLE->START, so it doubles as the stable conv_bin register
  assign conv.conv_bin = count;

  always_ff @(posedge mclk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next      = state;
    conv.conv_start = 1'b0;
    case (state)
      ST_IDLE:  if (tick || pending) state_next = ST_START;
      ST_START: begin
        conv.conv_start = 1'b1;
        state_next      = ST_WAIT;
      end
      ST_WAIT:  if (conv.conv_rdy || to_hit) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      tick_cnt <= '0;
      to_cnt   <= '0;
      count    <= '0;
      pending  <= 1'b0;
      stat_bcd <= '0;
      err      <= 1'b0;
    end else begin
      if (run) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

      if (launch) begin
        count   <= count_next;
        pending <= 1'b0;
      end else if (tick && state != ST_IDLE) begin
        pending <= 1'b1;
      end

      if (state == ST_START) to_cnt <= '0;

      if (state == ST_WAIT) begin
        if (conv.conv_rdy)  stat_bcd <= conv.conv_bcd;
        else if (to_hit)    err      <= 1'b1;
        else                to_cnt   <= to_cnt + 1'b1;
      end
    end
  end

  count_display_ctrl_scan_mux #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .mclk      (mclk),
    .rst       (rst),
    .bcd       (stat_bcd),
    .digit_sel (digit_sel),
    .digit_bcd (digit_bcd),
    .an        (an)
  );

endmodule

// File: tb/tb_count_display_ctrl.sv
// Directed bench: instance A (TIMEOUT=7) for counting/timeout/scan/reset/wrap, instance B (TIMEOUT=15) for overlap.
module tb_count_display_ctrl;

  localparam int unsigned TIMEOUT_A = 7;

  logic        mclk = 1'b0;
  logic        rst  = 1'b1;
  logic        run  = 1'b0;

  logic [15:0] stat_a, stat_b;
  logic [1:0]  sel_a, sel_b;
  logic [3:0]  dbcd_a, dbcd_b;
  logic [3:0]  an_a, an_b;
  logic        err_a, err_b;

  count_display_ctrl_if ifa ();
  count_display_ctrl_if ifb ();

  count_display_ctrl #(
    .TICK_DIV(8), .SCAN_DIV(4), .CNT_MAX(4095), .TIMEOUT(TIMEOUT_A)
  ) u_dut_a (
    .mclk(mclk), .rst(rst), .run(run), .conv(ifa),
    .stat_bcd(stat_a), .digit_sel(sel_a), .digit_bcd(dbcd_a), .an(an_a), .err(err_a)
  );

  count_display_ctrl #(
    .TICK_DIV(8), .SCAN_DIV(4), .CNT_MAX(4095), .TIMEOUT(15)
  ) u_dut_b (
    .mclk(mclk), .rst(rst), .run(run), .conv(ifb),
    .stat_bcd(stat_b), .digit_sel(sel_b), .digit_bcd(dbcd_b), .an(an_b), .err(err_b)
  );

  always #5 mclk = ~mclk;

  function automatic logic [15:0] to_bcd(input logic [11:0] v);
    int unsigned x;
    x = v;
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  // Converter models: rdy pulses <delay> cycles after the start cycle; delay 0 never answers.
  int          a_delay = 3, a_cnt = 0;
  int          b_delay = 3, b_cnt = 0;
  logic        a_ovr = 1'b0;
  logic [15:0] a_ovr_val = '0;

  always @(posedge mclk) begin
    if (ifa.conv_start) a_cnt <= a_delay;
    else if (a_cnt > 0) a_cnt <= a_cnt - 1;
    if (ifb.conv_start) b_cnt <= b_delay;
    else if (b_cnt > 0) b_cnt <= b_cnt - 1;
  end

  assign ifa.conv_rdy = (a_cnt == 1);
  assign ifa.conv_bcd = a_ovr ? a_ovr_val : to_bcd(ifa.conv_bin);
  assign ifb.conv_rdy = (b_cnt == 1);
  assign ifb.conv_bcd = to_bcd(ifb.conv_bin);

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic wait_start(input bit use_b, input int limit, output int dt);
    logic s;
    dt = 0;
    s  = 1'b0;
    while (!s && dt < limit) begin
      @(negedge mclk);
      dt++;
      s = use_b ? ifb.conv_start : ifa.conv_start;
    end
    if (!s) begin
      checks++;
      $display("FAIL %s: got no conv_start, expected one within %0d cycles",
               use_b ? "start_b" : "start_a", limit);
    end
  endtask

  typedef struct {
    int          delay;
    int          gap;
    logic [11:0] bin;
    logic [15:0] stat;
    logic        err;
  } conv_vec_t;

  typedef struct {
    logic [3:0] an;
    logic [3:0] bcd;
    logic [1:0] sel;
  } scan_vec_t;

  conv_vec_t   vecs[6];
  scan_vec_t   scan[4];
  int          dt, w, found, starts;
  logic [15:0] prev_stat;
  logic        prev_err;
  logic [3:0]  prev_an;
  logic        seen;

  initial begin
    // delay, start gap, conv_bin, stat_bcd after, err after
    vecs[0] = '{3, 8, 12'd1, 16'h0001, 1'b0};
    vecs[1] = '{1, 4, 12'd2, 16'h0002, 1'b0};
    vecs[2] = '{3, 6, 12'd3, 16'h0003, 1'b0};
    vecs[3] = '{0, 4, 12'd4, 16'h0003, 1'b1};
    vecs[4] = '{3, 1, 12'd5, 16'h0005, 1'b1};
    vecs[5] = '{7, 3, 12'd6, 16'h0006, 1'b1};
    scan[0] = '{4'b1110, 4'h4, 2'd0};
    scan[1] = '{4'b1101, 4'h3, 2'd1};
    scan[2] = '{4'b1011, 4'h2, 2'd2};
    scan[3] = '{4'b0111, 4'h1, 2'd3};

    repeat (3) @(negedge mclk);
    check("rst_stat", stat_a, 16'h0);
    check("rst_an", an_a, 4'b1110);
    check("rst_start", ifa.conv_start, 1'b0);
    rst = 1'b0;
    run = 1'b1;

    // Counting, earliest latency, timeout, pending-after-timeout, rdy on the last WAIT cycle
    prev_stat = '0;
    prev_err  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wait_start(1'b0, 20, dt);
      a_delay = vecs[i].delay;
      check($sformatf("v%0d_gap", i), dt, vecs[i].gap);
      check($sformatf("v%0d_bin", i), ifa.conv_bin, vecs[i].bin);
      w = (vecs[i].delay == 0) ? TIMEOUT_A + 1 : vecs[i].delay + 1;
      repeat (w - 1) @(negedge mclk);
      check($sformatf("v%0d_stat_pre", i), stat_a, prev_stat);
      check($sformatf("v%0d_err_pre", i), err_a, prev_err);
      @(negedge mclk);
      check($sformatf("v%0d_stat", i), stat_a, vecs[i].stat);
      check($sformatf("v%0d_err", i), err_a, vecs[i].err);
      prev_stat = vecs[i].stat;
      prev_err  = vecs[i].err;
    end

    // Scan: load 0x1234, stop counting, then watch one full anode rotation
    a_ovr     = 1'b1;
    a_ovr_val = 16'h1234;
    wait_start(1'b0, 20, dt);
    a_delay = 1;
    run     = 1'b0;
    repeat (2) @(negedge mclk);
    check("scan_stat", stat_a, 16'h1234);
    @(negedge mclk);
    prev_an = an_a;
    seen    = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge mclk);
      seen    = (an_a == 4'b1110) && (prev_an != 4'b1110);
      prev_an = an_a;
    end
    check("scan_sync", seen, 1'b1);
    for (int i = 0; i < 17; i++) begin
      if (i > 0) @(negedge mclk);
      check($sformatf("scan_c%0d", i), {an_a, dbcd_a, sel_a},
            {scan[(i / 4) % 4].an, scan[(i / 4) % 4].bcd, scan[(i / 4) % 4].sel});
    end

    // Reset during WAIT: late rdy lands in IDLE and must be ignored
    a_delay = 4;
    run     = 1'b1;
    wait_start(1'b0, 20, dt);
    @(negedge mclk);
    rst = 1'b1;
    run = 1'b0;
    @(negedge mclk);
    rst = 1'b0;
    check("mrst_start", ifa.conv_start, 1'b0);
    check("mrst_bin", ifa.conv_bin, 12'd0);
    check("mrst_stat", stat_a, 16'h0);
    check("mrst_err", err_a, 1'b0);
    check("mrst_sel", sel_a, 2'd0);
    check("mrst_an", an_a, 4'b1110);
    check("mrst_dbcd", dbcd_a, 4'h0);
    starts = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge mclk);
      if (ifa.conv_start) starts++;
    end
    check("mrst_no_start", starts, 0);
    check("mrst_stat_late", stat_a, 16'h0);

    // Wrap-around: 4095 then 0
    a_ovr   = 1'b0;
    a_delay = 1;
    run     = 1'b1;
    found   = -1;
    for (int i = 0; i < 4100; i++) begin
      wait_start(1'b0, 12, dt);
      if (ifa.conv_start !== 1'b1) break;
      if (ifa.conv_bin == 12'd4095) begin
        found = i;
        break;
      end
    end
    check("wrap_index", found, 4094);
    repeat (2) @(negedge mclk);
    check("wrap_stat_max", stat_a, 16'h4095);
    wait_start(1'b0, 12, dt);
    check("wrap_bin_zero", ifa.conv_bin, 12'd0);
    repeat (2) @(negedge mclk);
    check("wrap_stat_zero", stat_a, 16'h0000);
    check("wrap_err", err_a, 1'b0);

    // Overlap on instance B: pending served after rdy, then two ticks in one WAIT keep only one
    rst     = 1'b1;
    run     = 1'b0;
    b_delay = 10;
    repeat (2) @(negedge mclk);
    rst = 1'b0;
    run = 1'b1;
    wait_start(1'b1, 20, dt);
    check("ovl_dt1", dt, 8);
    check("ovl_bin1", ifb.conv_bin, 12'd1);
    wait_start(1'b1, 20, dt);
    b_delay = 0;
    check("ovl_dt2", dt, 12);
    check("ovl_bin2", ifb.conv_bin, 12'd2);
    check("ovl_stat2", stat_b, 16'h0001);
    wait_start(1'b1, 30, dt);
    b_delay = 1;
    check("ovl_dt3", dt, 17);
    check("ovl_bin3", ifb.conv_bin, 12'd3);
    check("ovl_err3", err_b, 1'b1);
    check("ovl_stat3", stat_b, 16'h0001);
    wait_start(1'b1, 20, dt);
    check("ovl_dt4", dt, 3);
    check("ovl_bin4", ifb.conv_bin, 12'd4);
    wait_start(1'b1, 20, dt);
    check("ovl_dt5", dt, 8);
    check("ovl_bin5", ifb.conv_bin, 12'd5);
    check("ovl_stat5", stat_b, 16'h0004);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/count_display_ctrl.md
Name: count_display_ctrl

Overview:
Sequencer for the count → binary-to-BCD → 7-segment path. It paces a 12-bit up-counter and hands each new value to the external bin2bcd converter using a start/rdy handshake. It latches the converted BCD word and time-multiplexes it onto the four-digit anode/segment driver. It replaces the free-running glue logic and adds timeout protection plus a deterministic display scan.

Parameters:
TICK_DIV, 50_000_000, mclk cycles per count tick (≥4)
SCAN_DIV, 100_000, mclk cycles per digit-scan step (≥2)
CNT_MAX, 4095, terminal count value; the counter wraps to 0 after it
TIMEOUT, 31, maximum cycles spent in WAIT before abort (≥1)

Ports:
mclk  in  1  system clock; single clock domain
rst  in  1  synchronous reset, active-high
run  in  1  count enable; when 0, the tick divider holds and no new conversions start
conv_start  out  1  one-cycle start pulse to bin2bcd
conv_bin  out  12  binary value presented to bin2bcd; stable from START until the FSM returns to IDLE
conv_rdy  in  1  bin2bcd result-valid flag, level or pulse
conv_bcd  in  16  bin2bcd result, 4 BCD digits, digit 0 in bits [3:0]
stat_bcd  out  16  last successfully converted BCD value
digit_sel  out  2  digit currently being driven (0..3)
digit_bcd  out  4  BCD nibble for the digit_sel digit
an  out  4  anode enables, active-low, one-hot-zero
err  out  1  sticky conversion-timeout flag

Behaviour:
- Clock and reset: all state changes on posedge mclk; rst is sampled synchronously and has priority over everything else.
- Reset values: count=0, conv_bin=0, conv_start=0, stat_bcd=0, err=0, state=IDLE, pending=0, tick/scan/timeout counters=0, digit_sel=0, an=4'b1110, digit_bcd=0.
- Tick generator: while run=1, the divider counts 0..TICK_DIV-1 and emits a 1-cycle internal tick on the terminal value. While run=0, the divider holds its value.
- Pending flag: set by a tick that arrives while the FSM is not in IDLE. It is 1 deep, so further overlapping ticks are dropped. It is cleared when consumed.
- FSM states: IDLE, START, WAIT.
- IDLE: on tick or pending, go to START. At that edge, count becomes (count==CNT_MAX) ? 0 : count+1, conv_bin takes the new count, and pending clears. In IDLE, conv_rdy is ignored (stale).
- START: conv_start=1 for exactly this cycle; the timeout counter clears; go to WAIT.
- WAIT, conv_rdy=1: on that edge stat_bcd<=conv_bcd; go to IDLE.
- WAIT, timeout counter reaches TIMEOUT with no rdy: err<=1, stat_bcd unchanged, go to IDLE. The count is not rolled back.
- Latency: tick cycle t → conv_start high in cycle t+1 → earliest stat_bcd update at the edge ending cycle t+2 (rdy sampled in the first WAIT cycle).
- err: cleared only by rst.
- Scan: an independent divider counts 0..SCAN_DIV-1. On its terminal value, digit_sel increments and wraps 3→0.
- Display outputs (registered): an=~(4'b0001<<digit_sel); digit_bcd=stat_bcd[4*digit_sel +: 4]. A stat_bcd change is reflected on digit_bcd one cycle later.
- run deasserted mid-conversion: the conversion completes normally. A pending tick is still served.
- Reset mid-WAIT: the conversion is abandoned. A late conv_rdy arrives in IDLE and is ignored.

Decomposition:
- Shared package: FSM state encoding (IDLE/START/WAIT), digit count constant 4, BCD width constants.
- Sub-module scan_mux: scan divider, digit_sel, an, and digit_bcd generation. Everything else stays in the top-level control FSM.

Test Plan:
(Bench parameters: TICK_DIV=8, SCAN_DIV=4, TIMEOUT=7; converter model raises rdy 3 cycles after start unless noted.)
1. Basic counting: rst then run=1 → conv_start pulses every 8 cycles with conv_bin=1,2,3; stat_bcd becomes 0x0001, 0x0002, 0x0003; err=0.
2. Wrap-around: run through 4096 ticks → conv_bin 4095 then 0; stat_bcd 0x4095 then 0x0000.
3. Timeout: converter never asserts rdy → err=1 exactly 7 cycles after the WAIT entry; stat_bcd holds its previous value; the next tick issues conv_bin=previous+1.
4. Overlapping tick (TIMEOUT=15, rdy 10 cycles late) → the tick during WAIT sets pending; conv_start re-fires 2 cycles after stat_bcd updates; no count skipped. A third overlapping tick is dropped.
5. Scan: force stat_bcd=0x1234 → an cycles 1110, 1101, 1011, 0111 with digit_bcd 4, 3, 2, 1, each held 4 cycles, wrapping back to 1110.
6. Reset mid-WAIT: rst pulse → next cycle shows all reset values; rdy arriving 2 cycles later leaves stat_bcd=0; run=0 after reset → no conv_start.
